wb_unit: RTL and testbench



---
 rtl/wb_unit.sv | 168 ++++++++++++++++
 tb/tb_wb_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_unit.sv
// Writeback stage: retires execute results and completes loads into the register file port.
// Loads wait for mem_rvalid (bounded by TIMEOUT) and are aligned and sign/zero-extended here.
module wb_unit #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic        ex_rd_we,
    input  logic [4:0]  ex_rd_addr,
    input  logic        ex_is_load,
    input  logic [2:0]  ex_funct3,
    input  logic [1:0]  ex_addr_lo,
    input  logic [31:0] ex_result,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        rd_we,
    output logic [4:0]  rd_addr,
    output logic [31:0] rd_data,
    output logic        busy,
    output logic [4:0]  busy_rd,
    output logic        fault,
    output logic [1:0]  fault_code,
    output logic [31:0] instret
);

    typedef enum logic [0:0] {StIdle, StWaitLoad} state_e;

    localparam logic [7:0] CntMax = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        ld_we_q, ld_we_d;
    logic [4:0]  ld_rd_q, ld_rd_d;
    logic [2:0]  ld_f3_q, ld_f3_d;
    logic [1:0]  ld_lo_q, ld_lo_d;

    logic        rd_we_d;
    logic [4:0]  rd_addr_d;
    logic [31:0] rd_data_d;
    logic        fault_d;
    logic [1:0]  fault_code_d;
    logic [31:0] instret_d;

    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] load_val;
    logic        f3_bad;
    logic        misaligned;

    assign ex_ready = (state_q == StIdle);
    assign busy     = (state_q == StWaitLoad);
    assign busy_rd  = busy ? ld_rd_q : 5'd0;

    assign f3_bad     = (ex_funct3 == 3'd3) || (ex_funct3[2:1] == 2'b11);
    assign misaligned = (((ex_funct3 == 3'd1) || (ex_funct3 == 3'd5)) && ex_addr_lo[0]) ||
                        ((ex_funct3 == 3'd2) && (ex_addr_lo != 2'd0));

    always_comb begin
        byte_v = mem_rdata[7:0];
        unique case (ld_lo_q)
            2'd0: byte_v = mem_rdata[7:0];
            2'd1: byte_v = mem_rdata[15:8];
            2'd2: byte_v = mem_rdata[23:16];
            2'd3: byte_v = mem_rdata[31:24];
        endcase
        half_v = ld_lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (ld_f3_q)
            3'd0:    load_val = {{24{byte_v[7]}}, byte_v};
            3'd1:    load_val = {{16{half_v[15]}}, half_v};
            3'd4:    load_val = {24'd0, byte_v};
            3'd5:    load_val = {16'd0, half_v};
            default: load_val = mem_rdata;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ld_we_d      = ld_we_q;
        ld_rd_d      = ld_rd_q;
        ld_f3_d      = ld_f3_q;
        ld_lo_d      = ld_lo_q;
        rd_we_d      = 1'b0;
        rd_addr_d    = rd_addr;
        rd_data_d    = rd_data;
        fault_d      = 1'b0;
        fault_code_d = fault_code;
        instret_d    = instret;
        unique case (state_q)
            StIdle: begin
                if (ex_valid) begin
                    if (!ex_is_load) begin
                        instret_d = instret + 32'd1;
                        // rd_addr/rd_data only move on an actual write so they hold otherwise
                        if (ex_rd_we && (ex_rd_addr != 5'd0)) begin
                            rd_we_d   = 1'b1;
                            rd_addr_d = ex_rd_addr;
                            rd_data_d = ex_result;
                        end
                    end else if (f3_bad) begin
                        fault_d      = 1'b1;
                        fault_code_d = 2'b10;
                    end else if (misaligned) begin
                        fault_d      = 1'b1;
                        fault_code_d = 2'b01;
                    end else begin
                        ld_we_d = ex_rd_we;
                        ld_rd_d = ex_rd_addr;
                        ld_f3_d = ex_funct3;
                        ld_lo_d = ex_addr_lo;
                        cnt_d   = 8'd0;
                        state_d = StWaitLoad;
                    end
                end
            end
            StWaitLoad: begin
                if (mem_rvalid) begin
                    instret_d = instret + 32'd1;
                    state_d   = StIdle;
                    if (ld_we_q && (ld_rd_q != 5'd0)) begin
                        rd_we_d   = 1'b1;
                        rd_addr_d = ld_rd_q;
                        rd_data_d = load_val;
                    end
                end else if (cnt_q == CntMax) begin
                    fault_d      = 1'b1;
                    fault_code_d = 2'b11;
                    state_d      = StIdle;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= 8'd0;
            ld_we_q    <= 1'b0;
            ld_rd_q    <= 5'd0;
            ld_f3_q    <= 3'd0;
            ld_lo_q    <= 2'd0;
            rd_we      <= 1'b0;
            rd_addr    <= 5'd0;
            rd_data    <= 32'd0;
            fault      <= 1'b0;
            fault_code <= 2'b00;
            instret    <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ld_we_q    <= ld_we_d;
            ld_rd_q    <= ld_rd_d;
            ld_f3_q    <= ld_f3_d;
            ld_lo_q    <= ld_lo_d;
            rd_we      <= rd_we_d;
            rd_addr    <= rd_addr_d;
            rd_data    <= rd_data_d;
            fault      <= fault_d;
            fault_code <= fault_code_d;
            instret    <= instret_d;
        end
    end

endmodule

// File: tb/tb_wb_unit.sv
// Bench for wb_unit: directed scenarios plus random traffic against a transaction-level model.
module tb_wb_unit;
    localparam int unsigned TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_ready, ex_rd_we, ex_is_load;
    logic [4:0]  ex_rd_addr;
    logic [2:0]  ex_funct3;
    logic [1:0]  ex_addr_lo;
    logic [31:0] ex_result;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        rd_we, busy, fault;
    logic [4:0]  rd_addr, busy_rd;
    logic [31:0] rd_data, instret;
    logic [1:0]  fault_code;

    int checks = 0;
    int errors = 0;

    wb_unit #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_rd_we(ex_rd_we),
        .ex_rd_addr(ex_rd_addr), .ex_is_load(ex_is_load), .ex_funct3(ex_funct3),
        .ex_addr_lo(ex_addr_lo), .ex_result(ex_result), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .rd_we(rd_we), .rd_addr(rd_addr), .rd_data(rd_data),
        .busy(busy), .busy_rd(busy_rd), .fault(fault), .fault_code(fault_code),
        .instret(instret)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Value a load must return, from byte/halfword arithmetic on the memory word.
    function automatic logic [31:0] load_value(input int f3, input int lo, input logic [31:0] w);
        logic [31:0] b, h;
        b = (w >> (8 * lo)) % 256;
        h = (w >> (16 * (lo / 2))) % 65536;
        case (f3)
            0:       return (b >= 128) ? b + 32'hFFFFFF00 : b;
            1:       return (h >= 32768) ? h + 32'hFFFF0000 : h;
            4:       return b;
            5:       return h;
            default: return w;
        endcase
    endfunction

    // Transaction model: one optional pending load plus the count of cycles it has waited.
    bit          m_valid = 0;
    bit          pend;
    int          waited;
    bit          p_we;
    int          p_rd, p_f3, p_lo;
    bit          e_we, e_fault;
    logic [4:0]  e_addr;
    logic [31:0] e_data, e_instret;
    logic [1:0]  e_code;

    always @(posedge clk) begin
        e_we    = 0;
        e_fault = 0;
        if (rst) begin
            m_valid   = 1;
            pend      = 0;
            e_addr    = 0;
            e_data    = 0;
            e_code    = 0;
            e_instret = 0;
        end else if (!pend) begin
            if (ex_valid) begin
                if (!ex_is_load) begin
                    e_instret = e_instret + 1;
                    if (ex_rd_we && ex_rd_addr != 0) begin
                        e_we = 1; e_addr = ex_rd_addr; e_data = ex_result;
                    end
                end else if (ex_funct3 == 3 || ex_funct3 == 6 || ex_funct3 == 7) begin
                    e_fault = 1; e_code = 2;
                end else if (((ex_funct3 == 1 || ex_funct3 == 5) && ex_addr_lo % 2 == 1) ||
                             (ex_funct3 == 2 && ex_addr_lo != 0)) begin
                    e_fault = 1; e_code = 1;
                end else begin
                    pend = 1; waited = 0;
                    p_we = ex_rd_we; p_rd = ex_rd_addr; p_f3 = ex_funct3; p_lo = ex_addr_lo;
                end
            end
        end else if (mem_rvalid) begin
            pend      = 0;
            e_instret = e_instret + 1;
            if (p_we && p_rd != 0) begin
                e_we = 1; e_addr = 5'(p_rd); e_data = load_value(p_f3, p_lo, mem_rdata);
            end
        end else begin
            waited++;
            if (waited == TIMEOUT) begin
                pend = 0; e_fault = 1; e_code = 3;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("rd_we", 32'(rd_we), 32'(e_we));
            check("fault", 32'(fault), 32'(e_fault));
            check("instret", instret, e_instret);
            check("busy", 32'(busy), 32'(pend));
            check("busy_rd", 32'(busy_rd), pend ? 32'(p_rd) : 32'd0);
            check("ex_ready", 32'(ex_ready), 32'(!pend));
            if (e_we) begin
                check("rd_addr", 32'(rd_addr), 32'(e_addr));
                check("rd_data", rd_data, e_data);
            end
            if (e_fault) check("fault_code", 32'(fault_code), 32'(e_code));
        end
    end

    task automatic send(input bit ld, input int f3, input int lo, input int rd, input bit we,
                        input logic [31:0] res);
        ex_valid = 1; ex_is_load = ld; ex_funct3 = 3'(f3); ex_addr_lo = 2'(lo);
        ex_rd_addr = 5'(rd); ex_rd_we = we; ex_result = res;
        @(negedge clk);
        ex_valid = 0;
    endtask

    task automatic respond(input logic [31:0] w);
        mem_rvalid = 1; mem_rdata = w;
        @(negedge clk);
        mem_rvalid = 0;
    endtask

    logic [31:0] saved;

    initial begin
        rst = 1; ex_valid = 0; ex_rd_we = 0; ex_rd_addr = 0; ex_is_load = 0; ex_funct3 = 0;
        ex_addr_lo = 0; ex_result = 0; mem_rvalid = 0; mem_rdata = 0;

        check("model_lb", load_value(0, 3, 32'h80FF0011), 32'hFFFFFF80);
        check("model_lhu", load_value(5, 2, 32'hBEEF1234), 32'h0000BEEF);
        check("model_lh", load_value(1, 2, 32'hBEEF1234), 32'hFFFFBEEF);
        check("model_lbu", load_value(4, 1, 32'h80FF0011), 32'h00000000);

        repeat (2) @(negedge clk);
        check("rst_rd_data", rd_data, 32'd0);
        check("rst_rd_addr", 32'(rd_addr), 32'd0);
        check("rst_code", 32'(fault_code), 32'd0);
        check("rst_ready", 32'(ex_ready), 32'd1);
        rst = 0;

        send(0, 0, 0, 5, 1, 32'h12345678);
        check("t1_we", 32'(rd_we), 32'd1);
        check("t1_data", rd_data, 32'h12345678);
        check("t1_instret", instret, 32'd1);
        send(0, 0, 0, 0, 1, 32'hDEADBEEF);
        check("t1_x0_we", 32'(rd_we), 32'd0);
        check("t1_x0_instret", instret, 32'd2);

        send(1, 0, 3, 7, 1, 0);
        check("t2_busy_rd", 32'(busy_rd), 32'd7);
        @(negedge clk);
        respond(32'h80FF0011);
        check("t2_data", rd_data, 32'hFFFFFF80);

        send(1, 5, 2, 8, 1, 0);
        respond(32'hBEEF1234);
        check("t3_lhu", rd_data, 32'h0000BEEF);
        send(1, 1, 2, 8, 1, 0);
        respond(32'hBEEF1234);
        check("t3_lh", rd_data, 32'hFFFFBEEF);

        saved = instret;
        send(1, 2, 2, 9, 1, 0);
        check("t4_code", 32'(fault_code), 32'd1);
        check("t4_instret", instret, saved);
        send(1, 3, 0, 9, 1, 0);
        check("t4_f3_code", 32'(fault_code), 32'd2);

        send(1, 2, 0, 9, 1, 0);
        repeat (15) @(negedge clk);
        check("t5_no_early_fault", 32'(fault), 32'd0);
        @(negedge clk);
        check("t5_timeout", {30'd0, fault_code} | 32'(fault) << 4, 32'h13);
        saved = instret;
        respond(32'h55555555);
        check("t5_stray_we", 32'(rd_we), 32'd0);
        check("t5_stray_instret", instret, saved);
        send(1, 2, 0, 9, 1, 0);
        repeat (15) @(negedge clk);
        respond(32'hCAFEF00D);
        check("t5_last_cycle", rd_data, 32'hCAFEF00D);

        send(1, 2, 0, 10, 1, 0);
        repeat (2) @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        check("t6_instret", instret, 32'd0);
        check("t6_ready", 32'(ex_ready), 32'd1);
        respond(32'h77777777);
        check("t6_stray_we", 32'(rd_we), 32'd0);

        for (int i = 0; i < 4000; i++) begin
            ex_valid   = ($urandom_range(0, 2) != 0);
            ex_is_load = $urandom_range(0, 1) == 1;
            ex_funct3  = 3'($urandom);
            ex_addr_lo = 2'($urandom);
            ex_rd_addr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            ex_rd_we   = $urandom_range(0, 3) != 0;
            ex_result  = $urandom;
            mem_rvalid = (i % 1000 < 500) ? ($urandom_range(0, 3) == 0)
                                          : ($urandom_range(0, 14) == 0);
            mem_rdata  = $urandom;
            rst        = ($urandom_range(0, 299) == 0);
            @(negedge clk);
        end
        rst = 0; ex_valid = 0; mem_rvalid = 0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
